// File: rtl/cordic_phase_sched_pkg.sv
// Shared configuration and types for the CORDIC phase scheduler.
// The tag carries the requester ID alongside the core's sample pipeline.
package cordic_phase_sched_pkg;

    localparam int N   = 2;
    localparam int IW  = 7;
    localparam int PW  = 4;
    localparam int LAT = 5;
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(LAT + 1);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/cordic_tag_pipe.sv
// Tag shadow pipeline matched to the core latency.
// Also keeps a registered count of valid tags in flight.
import cordic_phase_sched_pkg::*;

module cordic_tag_pipe (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_ce,
    input  logic           i_issue,
    input  logic [IDW-1:0] i_id,
    output tag_t           o_tail,
    output logic [CW-1:0]  o_inflight
);

    tag_t tags [LAT];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LAT; i++)
                tags[i] <= '0;
            o_inflight <= '0;
        end else if (i_ce) begin
            tags[0] <= '{valid: i_issue, id: i_id};
            for (int i = 1; i < LAT; i++)
                tags[i] <= tags[i-1];
            case ({i_issue, tags[LAT-1].valid})
                2'b10:   o_inflight <= o_inflight + 1'b1;
                2'b01:   o_inflight <= o_inflight - 1'b1;
                default: ;
            endcase
        end
    end

    assign o_tail = tags[LAT-1];

endmodule

// File: rtl/cordic_phase_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC phase core.
// Results are routed back to requesters by a latency-matched tag.
import cordic_phase_sched_pkg::*;

module cordic_phase_sched (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_ce,
    input  logic [N-1:0]   i_req_valid,
    input  logic [N*IW-1:0] i_req_x,
    input  logic [N*IW-1:0] i_req_y,
    output logic [N-1:0]   o_req_ready,
    output logic [IW-1:0]  o_cx,
    output logic [IW-1:0]  o_cy,
    input  logic [PW-1:0]  i_cphase,
    output logic [N-1:0]   o_rsp_valid,
    output logic [PW-1:0]  o_rsp_phase,
    input  logic           i_drain,
    output logic           o_idle,
    output logic [CW-1:0]  o_inflight
);

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW:0]   cand;
    logic           grant;
    tag_t           tail;

    // Search from rr_ptr+1 and wrap once; first valid requester wins.
    always_comb begin
        win   = '0;
        grant = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i + 1);
            if (cand >= (IDW+1)'(N))
                cand = cand - (IDW+1)'(N);
            if (!grant && i_req_valid[cand[IDW-1:0]]) begin
                grant = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
        if (state != RUN || !i_ce)
            grant = 1'b0;
    end

    assign o_req_ready = grant ? (N'(1) << win) : '0;
    assign o_cx = grant ? i_req_x[win*IW +: IW] : '0;
    assign o_cy = grant ? i_req_y[win*IW +: IW] : '0;

    cordic_tag_pipe u_tags (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_issue    (grant),
        .i_id       (win),
        .o_tail     (tail),
        .o_inflight (o_inflight)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            o_idle <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (!i_drain) begin
                    state  <= RUN;
                    o_idle <= 1'b0;
                end
                RUN: if (i_drain)
                    state <= DRAIN;
                DRAIN: if (o_inflight == '0) begin
                    state  <= IDLE;
                    o_idle <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    o_idle <= 1'b1;
                end
            endcase
        end
    end

    // Strobe lasts one cycle even if i_ce then stays low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr      <= '0;
            o_rsp_valid <= '0;
            o_rsp_phase <= '0;
        end else begin
            o_rsp_valid <= '0;
            if (i_ce && tail.valid) begin
                o_rsp_valid <= N'(1) << tail.id;
                o_rsp_phase <= i_cphase;
            end
            if (grant)
                rr_ptr <= win;
        end
    end

endmodule

// File: tb/tb_cordic_phase_sched.sv
// Randomized bench for cordic_phase_sched against a queue-based model.
// A stub core returns x[PW-1:0] delayed LAT enabled edges.
module tb_cordic_phase_sched;
    import cordic_phase_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0;
    logic drain = 1'b0;
    logic [N-1:0] req_v;
    logic [IW-1:0] req_x [N];
    logic [IW-1:0] req_y [N];
    logic [N*IW-1:0] bx, by;
    logic [N-1:0] ready, rsp_v;
    logic [IW-1:0] cx, cy;
    logic [PW-1:0] cphase, rsp_ph;
    logic idle;
    logic [CW-1:0] infl;
    logic [IW-1:0] stg [LAT];

    always #5 clk = ~clk;

    always_comb begin
        bx = '0;
        by = '0;
        for (int k = 0; k < N; k++) begin
            bx[k*IW +: IW] = req_x[k];
            by[k*IW +: IW] = req_y[k];
        end
    end

    cordic_phase_sched dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_ce        (ce),
        .i_req_valid (req_v),
        .i_req_x     (bx),
        .i_req_y     (by),
        .o_req_ready (ready),
        .o_cx        (cx),
        .o_cy        (cy),
        .i_cphase    (cphase),
        .o_rsp_valid (rsp_v),
        .o_rsp_phase (rsp_ph),
        .i_drain     (drain),
        .o_idle      (idle),
        .o_inflight  (infl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++)
                stg[i] <= '0;
        end else if (ce) begin
            stg[0] <= cx;
            for (int i = 1; i < LAT; i++)
                stg[i] <= stg[i-1];
        end
    end
    assign cphase = stg[LAT-1][PW-1:0];

    int checks = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int id;
        int ph;
        int left;
    } item_t;

    item_t pend [$];
    int mode = 0;
    int rr = 0;
    int e_rv = 0;
    int e_ph = 0;
    int g_ok, g_id;

    int p_req = 0;
    int p_ce = 100;
    logic [N-1:0] req_mask = '1;
    bit fix_x = 0;

    function automatic void predict();
        g_ok = 0;
        g_id = 0;
        if (mode == 1 && ce) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (rr + i) % N;
                if (g_ok == 0 && req_v[k]) begin
                    g_ok = 1;
                    g_id = k;
                end
            end
        end
    endfunction

    task automatic cycle();
        int old_n;
        int acc;
        predict();
        @(negedge clk);
        chk("ready", ready, g_ok != 0 ? (1 << g_id) : 0);
        chk("cx", cx, g_ok != 0 ? req_x[g_id] : 0);
        chk("cy", cy, g_ok != 0 ? req_y[g_id] : 0);
        chk("rsp_v", rsp_v, e_rv);
        chk("rsp_ph", rsp_ph, e_ph);
        chk("idle", idle, mode == 0);
        chk("inflight", infl, pend.size());
        @(posedge clk);
        acc = -1;
        if (rst) begin
            mode = 0;
            rr = 0;
            pend.delete();
            e_rv = 0;
            e_ph = 0;
        end else begin
            old_n = pend.size();
            e_rv = 0;
            if (ce) begin
                foreach (pend[i])
                    pend[i].left--;
                if (pend.size() > 0 && pend[0].left == 0) begin
                    e_rv = 1 << pend[0].id;
                    e_ph = pend[0].ph;
                    void'(pend.pop_front());
                end
                if (g_ok != 0) begin
                    pend.push_back('{g_id, int'(req_x[g_id][PW-1:0]), LAT});
                    rr = g_id;
                    acc = g_id;
                end
            end
            case (mode)
                0: if (!drain) mode = 1;
                1: if (drain) mode = 2;
                default: if (old_n == 0) mode = 0;
            endcase
        end
        #1;
        if (acc >= 0)
            req_v[acc] = 1'b0;
        ce = ($urandom_range(99) < p_ce);
        for (int k = 0; k < N; k++) begin
            if (!req_v[k] && req_mask[k] && $urandom_range(99) < p_req) begin
                req_v[k] = 1'b1;
                req_x[k] = fix_x ? IW'(k + 1) : IW'($urandom);
                req_y[k] = IW'($urandom);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            cycle();
    endtask

    initial begin
        req_v = '0;
        for (int k = 0; k < N; k++) begin
            req_x[k] = '0;
            req_y[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        run(2);

        // single request, always enabled
        req_v[0] = 1'b1;
        req_x[0] = 7'd5;
        req_y[0] = 7'd0;
        run(10);

        // both requesters streaming with fixed data
        fix_x = 1;
        p_req = 100;
        run(16);
        fix_x = 0;

        // clock enable toggling
        p_ce = 50;
        p_req = 60;
        run(40);

        // drain with requests still pending
        p_ce = 100;
        p_req = 100;
        run(4);
        drain = 1'b1;
        run(12);
        drain = 1'b0;
        run(8);

        // reset with results in flight
        run(3);
        rst = 1'b1;
        p_req = 0;
        cycle();
        rst = 1'b0;
        req_v = '0;
        run(2);
        req_v[0] = 1'b1;
        req_x[0] = 7'd9;
        run(9);

        // lone requester 1
        req_mask = 2'b10;
        p_req = 100;
        run(10);
        req_mask = '1;

        // random soak
        p_req = 50;
        p_ce = 70;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(29) == 0)
                drain = ~drain;
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
